// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared types and constants for the data-memory controller
package dm_ctrl_pkg;

  localparam int DM_ADDR_W = 12;
  localparam int DM_DATA_W = 32;
  localparam int DM_BE_W   = DM_DATA_W / 8;

  localparam logic [DM_BE_W-1:0] BE_FULL = 4'b1111;
  localparam logic [DM_BE_W-1:0] BE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    MERGE,
    DONE
  } state_t;

endpackage

// File: rtl/dm_ctrl_if.sv
// rtl/dm_ctrl_if.sv - requester ports and memory bus of the data-memory controller
interface dm_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;
  localparam int WA_W = ADDR_W - 2;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [BE_W-1:0]   be0, be1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic [WA_W-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;
  logic              owner;

  // Requesters plus the memory itself sit on the master side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1,
    input  ack0, ack1, rdata0, rdata1,
    input  mem_addr, mem_din, mem_wr, mem_rd,
    output mem_dout,
    input  busy, owner
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1,
    output ack0, ack1, rdata0, rdata1,
    output mem_addr, mem_din, mem_wr, mem_rd,
    input  mem_dout,
    output busy, owner
  );

endinterface

// File: rtl/dm_rr_arb2.sv
// rtl/dm_rr_arb2.sv - combinational two-way round-robin picker
module dm_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // On a conflict the port that was not served last wins.
  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - two-port arbitrated data-memory controller with sub-word read-modify-write
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input logic      clk,
  input logic      rst,
  dm_ctrl_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam int WA_W = ADDR_W - 2;

  state_t            state_q, state_d;
  logic              owner_q, rr_last_q, we_q;
  logic [WA_W-1:0]   addr_q;
  logic [DATA_W-1:0] wdata_q, merged_q, merged_d;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              gnt_valid, gnt_idx;
  logic              mem_rd_d, mem_wr_d, ack0_d, ack1_d;
  logic [WA_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0] mem_din_d;

  dm_rr_arb2 u_arb (
    .req      ({bus.req1, bus.req0}),
    .last     (rr_last_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    merged_d = bus.mem_dout;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) merged_d[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      merged_q  <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q <= state_d;
      // Fields are captured once at grant so requesters may change them afterwards.
      if (state_q == IDLE && gnt_valid) begin
        owner_q   <= gnt_idx;
        rr_last_q <= gnt_idx;
        we_q      <= gnt_idx ? bus.we1 : bus.we0;
        addr_q    <= gnt_idx ? bus.addr1[ADDR_W-1:2] : bus.addr0[ADDR_W-1:2];
        wdata_q   <= gnt_idx ? bus.wdata1 : bus.wdata0;
        be_q      <= gnt_idx ? bus.be1 : bus.be0;
      end
      if (state_q == WAIT) begin
        if (we_q) begin
          merged_q <= merged_d;
        end else if (owner_q) begin
          rdata1_q <= bus.mem_dout;
        end else begin
          rdata0_q <= bus.mem_dout;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = '0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (we_q && be_q == BE_FULL) begin
          mem_wr_d   = 1'b1;
          mem_din_d  = wdata_q;
          mem_addr_d = addr_q;
          state_d    = DONE;
        end else if (we_q && be_q == BE_NONE) begin
          state_d = DONE;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        state_d = we_q ? MERGE : DONE;
      end
      MERGE: begin
        mem_wr_d   = 1'b1;
        mem_din_d  = merged_q;
        mem_addr_d = addr_q;
        state_d    = DONE;
      end
      DONE: begin
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must suppress the write strobe so an aborted MERGE cannot corrupt memory.
    if (rst) begin
      mem_rd_d   = 1'b0;
      mem_wr_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
    end
  end

  assign bus.mem_rd   = mem_rd_d;
  assign bus.mem_wr   = mem_wr_d;
  assign bus.mem_addr = mem_addr_d;
  assign bus.mem_din  = mem_din_d;
  assign bus.ack0     = ack0_d;
  assign bus.ack1     = ack1_d;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.owner    = owner_q;

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Two-port controller in front of the word-only 4 KB data memory (1024 x 32, synchronous read and write).
- Shares the memory between the CPU load/store unit (port 0) and the loader/debug port (port 1) with round-robin arbitration.
- Turns byte-enabled sub-word stores into read-modify-write sequences, because the memory only writes whole words.
- Sits between the pipeline MEM stage and the data memory; it is the only driver of the memory's address, write-data, write-enable and read-enable.

Parameters:
- ADDR_W, 12, byte address width; word address is ADDR_W-1:2.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request valid; held until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  12  byte address; bits 1:0 are ignored.
- wdata0 / wdata1  in  32  write data, byte lanes aligned to the word.
- be0 / be1  in  4  byte enables; ignored for reads.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data; valid while ack is high, held until that port's next ack.
- mem_addr  out  10  word address to memory.
- mem_din  out  32  write data to memory.
- mem_wr  out  1  memory write enable.
- mem_rd  out  1  memory read enable.
- mem_dout  in  32  memory read data; valid the cycle after mem_rd.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the port currently being served.

Behaviour:
- Reset values: state=IDLE; ack0/1=0; rdata0/1=0; mem_wr=0; mem_rd=0; mem_addr=0; mem_din=0; busy=0; owner=0; rr_last=1, so port 0 wins the first conflict.
- Memory outputs are decoded from the registered state and the latched request. They are all 0 in IDLE and DONE, and in every state where they are not explicitly driven.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not rr_last.
  - On grant: latch we, addr[11:2], wdata and be into internal registers; set owner and rr_last to the winner; go to ISSUE.
- ISSUE:
  - Read: mem_rd=1, go to WAIT.
  - Write with be=4'b1111: mem_wr=1, mem_din=wdata, go to DONE.
  - Write with be=4'b0000: no memory access, go to DONE.
  - Any other write: mem_rd=1, go to WAIT.
- WAIT (mem_dout is valid):
  - Read: register mem_dout into rdata[owner], go to DONE.
  - Partial write: register merged data, where byte i = be[i] ? wdata byte i : mem_dout byte i; go to MERGE.
- MERGE: mem_wr=1, mem_din=merged, mem_addr=latched address; go to DONE.
- DONE: ack[owner]=1 for exactly one cycle; go to IDLE.
- Latency, from the IDLE cycle in which req is sampled to the ack cycle:
  - full-word write: 2 cycles;
  - be=0 write: 2 cycles;
  - read: 3 cycles;
  - partial write: 4 cycles.
- Handshake:
  - The requester keeps req and its fields stable until it samples ack=1, then drops req on that same edge.
  - If req is still high in the following IDLE cycle, that is a new request.
  - Fields are latched at grant, so changing them after grant has no effect.
- Fairness: under continuous requests from both ports, grants strictly alternate; neither port waits more than one transaction.
- A request arriving while busy=1 waits; it is not dropped.
- Reset during any state returns the block to IDLE with all reset values on the next edge.
  - No ack is issued for the aborted transaction.
  - An RMW aborted before MERGE leaves memory unmodified.
- Back-to-back accesses to the same word always observe the previous write, because transactions are fully serialised.

Decomposition:
- Package dm_ctrl_pkg:
  - state enum {IDLE, ISSUE, WAIT, MERGE, DONE};
  - BE_FULL=4'b1111 and BE_NONE=4'b0000;
  - ADDR_W and DATA_W defaults.
- One sub-module, dm_rr_arb2: 2-way round-robin picker with inputs req[1:0] and last, outputs gnt_valid and gnt_idx. It is purely combinational; the FSM owns the rr_last register.

Test Plan:
- Reset, then port 0 full write addr=0x010, wdata=0xDEADBEEF, be=1111 -> mem_wr=1 with mem_addr=0x004 on the ISSUE cycle; ack0 2 cycles after sampling; memory word 4 = 0xDEADBEEF.
- Port 1 read addr=0x010 after that write -> mem_rd in ISSUE; ack1 3 cycles after sampling; rdata1=0xDEADBEEF.
- Port 0 partial write addr=0x012, wdata=0x00AA0000, be=0100 -> read, then write 0xDEAABEEF; ack0 at cycle 4; a following read returns 0xDEAABEEF.
- req0 and req1 asserted in the same cycle, both held continuously for 4 transactions -> grant order 0,1,0,1; no port served twice in a row.
- Write with be=0000 -> no mem_wr and no mem_rd; ack 2 cycles after sampling; memory unchanged.
- rst asserted during MERGE of a partial write to word 4 -> next cycle IDLE with all outputs 0; no ack; word 4 still 0xDEAABEEF.
